// File: rtl/reg_file_reader_amisha.sv
// rtl/reg_file_reader_amisha.sv - streams a contiguous register-file window out on a valid/ready port (optional abort: REG_RD_ABORT_EN)
module reg_file_reader_amisha #(
  parameter int B_amisha = 8,
  parameter int W_amisha = 2
) (
  input  logic                clk_amisha,
  input  logic                rst_n_amisha,
  input  logic                start_amisha,
  input  logic [W_amisha-1:0] start_addr_amisha,
  input  logic [W_amisha:0]   count_amisha,
  output logic [W_amisha-1:0] r_addr_amisha,
  input  logic [B_amisha-1:0] r_data_amisha,
  output logic [B_amisha-1:0] out_data_amisha,
  output logic                out_valid_amisha,
  input  logic                out_ready_amisha,
`ifdef REG_RD_ABORT_EN
  input  logic                abort_amisha,
`endif
  output logic                busy_amisha,
  output logic                done_amisha
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Largest legal count: one pass over every register.
  localparam logic [W_amisha:0] DEPTH_amisha = {1'b1, {W_amisha{1'b0}}};

  state_t                state_q, state_d;
  logic [W_amisha-1:0]   addr_q, addr_d;
  logic [W_amisha:0]     rem_q, rem_d;
  logic [B_amisha-1:0]   data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  abort_hit;

`ifdef REG_RD_ABORT_EN
  assign abort_hit = abort_amisha;
`else
  assign abort_hit = 1'b0;
`endif

  assign r_addr_amisha    = addr_q;
  assign out_data_amisha  = data_q;
  assign out_valid_amisha = valid_q;
  assign busy_amisha      = busy_q;
  assign done_amisha      = done_q;

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
    if (!rst_n_amisha) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic; flags are registered from the next state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start_amisha) begin
          if (count_amisha == '0) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = start_addr_amisha;
            rem_d   = (count_amisha > DEPTH_amisha) ? DEPTH_amisha : count_amisha;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (abort_hit) begin
          valid_d = 1'b0;
          rem_d   = '0;
          state_d = ST_DONE;
        end else begin
          data_d  = r_data_amisha;
          valid_d = 1'b1;
          addr_d  = addr_q + W_amisha'(1);
          rem_d   = rem_q - (W_amisha+1)'(1);
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort_hit) begin
          valid_d = 1'b0;
          rem_d   = '0;
          state_d = ST_DONE;
        end else if (valid_q && out_ready_amisha) begin
          if (rem_q != '0) begin
            // Address already points at the next word, so refill on the same edge.
            data_d = r_data_amisha;
            addr_d = addr_q + W_amisha'(1);
            rem_d  = rem_q - (W_amisha+1)'(1);
          end else begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_FETCH) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

endmodule
